calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Control FSM for the keypad calculator: consumes decoded keypad codes, assembles the signed input buffer, latches operand 1, operator and operand 2, starts the arithmetic unit, and selects what the segment driver shows. Sits between the keypad driver and both the calculate unit and the segment driver, on the slow switch clock.

## Interface
- Parameters
- MAX_DIGITS, 8: maximum magnitude digits accepted per operand; further digit keys are ignored.
- TIMEOUT, 64: sw_clk cycles allowed between calc_start and calc_done before the sequencer declares an error.
- Ports
- sw_clk  in  1  sole clock. Divided switch clock.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: eBCD holds a new key this cycle.
- eBCD  in  4  key code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 sign toggle.
- calc_done  in  1  one-cycle strobe from the calculate unit: result valid.
- calc_err  in  1  qualified by calc_done: divide-by-zero or overflow.
- calc_result  in  32  signed result.
- operand1  out  32  signed first operand to the calculate unit.
- operand2  out  32  signed second operand.
- operator  out  3  0 add, 1 sub, 2 mul, 3 div; 4-7 unused.
- calc_start  out  1  one-cycle start pulse.
- fnd_serial  out  32  signed value for the segment driver.
- disp_err  out  1  high while an error is shown.
- busy  out  1  high in EXEC.

## Operation
- States: OP1 (entering operand 1), OPR (operator held, no operand-2 digit yet), OP2 (entering operand 2), EXEC (waiting on the calculate unit), RES (result shown), ERR.
- Input buffer: 31-bit magnitude plus a sign bit. A digit key with fewer than MAX_DIGITS digits entered sets buffer = buffer*10 + d. Sign toggle inverts the sign bit. The signed value is ±buffer.
- OP1: digit and sign keys edit the buffer. An operator key latches operand1 = signed buffer and sets operator, clears the buffer, and moves to OPR. Equals is ignored.
- OPR: a digit or sign key moves to OP2 and is applied. A further operator key replaces operator.
- OP2: digit and sign keys edit the buffer.
  - Equals latches operand2, pulses calc_start and enters EXEC with chain=0.
  - An operator key does the same with chain=1 and stores the new operator as pending.
- EXEC: all keys are ignored.
  - calc_done with calc_err=0: chain=0 goes to RES and shows calc_result. chain=1 sets operand1=calc_result, operator=pending, clears the buffer and goes to OPR.
  - calc_done with calc_err=1 goes to ERR.
  - TIMEOUT expiry goes to ERR.
- RES: an operator key sets operand1=result, latches operator and goes to OPR. A digit or sign key clears everything, applies the key and goes to OP1. Equals is ignored.
- ERR: disp_err=1 and fnd_serial=0. Any key clears all registers and goes to OP1; that key is discarded.
- Display selection: OP1/OP2 show the signed buffer, OPR shows operand1, RES shows the result.

## Timing
- Reset, asynchronous: all outputs 0, state OP1, buffer 0, sign 0, chain 0, timeout counter 0.
- A key accepted on edge N updates registers and fnd_serial on edge N; the value is visible in the cycle after N.
- calc_start is high for exactly the one cycle after the accepting edge. operand1, operand2 and operator are stable from that cycle until EXEC exits.
- The timeout counter starts at 0 in the calc_start cycle. ERR is entered on the edge where the count reaches TIMEOUT-1 without calc_done.
- calc_done and key_valid in the same cycle: calc_done is processed and the key is dropped.
- calc_done outside EXEC is ignored.
- Reset asserted mid-EXEC aborts immediately. No calc_start is reissued.

## Structure
- Package calc_pkg holds:
  - key code localparams (KEY_ADD..KEY_SIGN);
  - operator codes;
  - state encoding;
  - DISP_WIDTH=32.
- Sub-module digit_accumulator: buffer, sign and digit count, with ports for clear, digit, toggle and count-limit. It is shared by both operand-entry states.
- The FSM, operand/operator registers and timeout counter stay in calc_sequencer.

## Test plan
- Keys 1,2,+,3,= with calc_done (result 15) 2 cycles after start: operand1=12, operand2=3, operator=0, one calc_start, fnd_serial=15 in RES.
- Keys 5,sign,*,4,= : operand1=-5, operator=2; inject result -20: fnd_serial=-20.
- Keys 9×10: buffer=99,999,999 after 8 digits; the remaining digits are ignored.
- Keys 8,/,0,= with calc_err=1: ERR, disp_err=1, fnd_serial=0. The next key 7 goes to OP1 with fnd_serial=0; the next key 3 gives fnd_serial=3.
- Keys 2,+,3,- with result 5, then 1,= with result 4: second start has operand1=5, operator=1, operand2=1; RES shows 4.
- Keys 1,+,1,= with calc_done withheld: ERR exactly TIMEOUT cycles after calc_start. A key_valid during EXEC leaves operands unchanged. Reset mid-EXEC returns all outputs to 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, operator codes and FSM encoding for the keypad calculator.
package calc_pkg;

    localparam int DISP_WIDTH = 32;

    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_DIV  = 4'd13;
    localparam logic [3:0] KEY_EQ   = 4'd14;
    localparam logic [3:0] KEY_SIGN = 4'd15;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    typedef enum logic [2:0] {
        ST_OP1  = 3'd0,
        ST_OPR  = 3'd1,
        ST_OP2  = 3'd2,
        ST_EXEC = 3'd3,
        ST_RES  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Operator keys are contiguous, so the operator code is the offset from KEY_ADD.
    function automatic logic [2:0] key_to_op(input logic [3:0] key);
        return 3'(key - KEY_ADD);
    endfunction

endpackage

// File: rtl/calc_sequencer_digit_accumulator.sv
// Signed operand entry buffer: 31-bit magnitude, sign flag and digit count.
// A clear in the same cycle as a digit/toggle applies first, so one key can restart entry.
module digit_accumulator
    import calc_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         digit_en,
    input  logic [3:0]                   digit,
    input  logic                         toggle,
    input  logic [3:0]                   max_digits,
    output logic signed [DISP_WIDTH-1:0] value
);

    logic [30:0] mag;
    logic [30:0] mag_base;
    logic        neg;
    logic        neg_base;
    logic [3:0]  cnt;
    logic [3:0]  cnt_base;

    always_comb begin
        mag_base = clr ? '0 : mag;
        neg_base = clr ? 1'b0 : neg;
        cnt_base = clr ? '0 : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
            neg <= 1'b0;
            cnt <= '0;
        end else begin
            if (digit_en && (cnt_base < max_digits)) begin
                mag <= mag_base * 31'd10 + {27'd0, digit};
                cnt <= cnt_base + 4'd1;
            end else begin
                mag <= mag_base;
                cnt <= cnt_base;
            end
            neg <= neg_base ^ toggle;
        end
    end

    assign value = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: builds operands from key codes, launches the
// calculate unit, handles chained operators, timeouts and the display select.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                         sw_clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [3:0]                   eBCD,
    input  logic                         calc_done,
    input  logic                         calc_err,
    input  logic signed [DISP_WIDTH-1:0] calc_result,
    output logic signed [DISP_WIDTH-1:0] operand1,
    output logic signed [DISP_WIDTH-1:0] operand2,
    output logic [2:0]                   operator,
    output logic                         calc_start,
    output logic signed [DISP_WIDTH-1:0] fnd_serial,
    output logic                         disp_err,
    output logic                         busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                       state, state_nxt;
    logic signed [DISP_WIDTH-1:0] op1_nxt, op2_nxt, result, res_nxt, acc_value;
    logic [2:0]                   opr_nxt, pending_op, pend_nxt;
    logic                         chain, chain_nxt, start_nxt;
    logic [TMO_W-1:0]             tmo_cnt, tmo_nxt;
    logic                         acc_clr, acc_digit, acc_toggle;
    logic                         key_digit, key_sign, key_eq, key_oper;

    assign key_digit = key_valid && (eBCD <= 4'd9);
    assign key_sign  = key_valid && (eBCD == KEY_SIGN);
    assign key_eq    = key_valid && (eBCD == KEY_EQ);
    assign key_oper  = key_valid && (eBCD >= KEY_ADD) && (eBCD <= KEY_DIV);

    digit_accumulator u_acc (
        .clk        (sw_clk),
        .rst_n      (rst),
        .clr        (acc_clr),
        .digit_en   (acc_digit),
        .digit      (eBCD),
        .toggle     (acc_toggle),
        .max_digits (4'(MAX_DIGITS)),
        .value      (acc_value)
    );

    always_comb begin
        state_nxt  = state;
        op1_nxt    = operand1;
        op2_nxt    = operand2;
        opr_nxt    = operator;
        pend_nxt   = pending_op;
        chain_nxt  = chain;
        res_nxt    = result;
        start_nxt  = 1'b0;
        tmo_nxt    = tmo_cnt;
        acc_clr    = 1'b0;
        acc_digit  = 1'b0;
        acc_toggle = 1'b0;
        case (state)
            ST_OP1: begin
                acc_digit  = key_digit;
                acc_toggle = key_sign;
                if (key_oper) begin
                    op1_nxt   = acc_value;
                    opr_nxt   = key_to_op(eBCD);
                    acc_clr   = 1'b1;
                    state_nxt = ST_OPR;
                end
            end
            ST_OPR: begin
                if (key_digit || key_sign) begin
                    acc_digit  = key_digit;
                    acc_toggle = key_sign;
                    state_nxt  = ST_OP2;
                end else if (key_oper) begin
                    opr_nxt = key_to_op(eBCD);
                end
            end
            ST_OP2: begin
                acc_digit  = key_digit;
                acc_toggle = key_sign;
                // An operator key here both computes and queues the next operation.
                if (key_eq || key_oper) begin
                    op2_nxt   = acc_value;
                    acc_clr   = 1'b1;
                    start_nxt = 1'b1;
                    tmo_nxt   = '0;
                    chain_nxt = key_oper;
                    if (key_oper) pend_nxt = key_to_op(eBCD);
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (calc_done) begin
                    tmo_nxt = '0;
                    if (calc_err) begin
                        state_nxt = ST_ERR;
                    end else if (chain) begin
                        op1_nxt   = calc_result;
                        opr_nxt   = pending_op;
                        chain_nxt = 1'b0;
                        acc_clr   = 1'b1;
                        state_nxt = ST_OPR;
                    end else begin
                        res_nxt   = calc_result;
                        state_nxt = ST_RES;
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    tmo_nxt   = '0;
                    state_nxt = ST_ERR;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_RES: begin
                if (key_oper) begin
                    op1_nxt   = result;
                    opr_nxt   = key_to_op(eBCD);
                    state_nxt = ST_OPR;
                end else if (key_digit || key_sign) begin
                    op1_nxt    = '0;
                    op2_nxt    = '0;
                    opr_nxt    = OP_ADD;
                    pend_nxt   = OP_ADD;
                    chain_nxt  = 1'b0;
                    res_nxt    = '0;
                    acc_clr    = 1'b1;
                    acc_digit  = key_digit;
                    acc_toggle = key_sign;
                    state_nxt  = ST_OP1;
                end
            end
            ST_ERR: begin
                if (key_valid) begin
                    op1_nxt   = '0;
                    op2_nxt   = '0;
                    opr_nxt   = OP_ADD;
                    pend_nxt  = OP_ADD;
                    chain_nxt = 1'b0;
                    res_nxt   = '0;
                    acc_clr   = 1'b1;
                    state_nxt = ST_OP1;
                end
            end
            default: state_nxt = ST_OP1;
        endcase
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_OP1;
            operand1   <= '0;
            operand2   <= '0;
            operator   <= OP_ADD;
            pending_op <= OP_ADD;
            chain      <= 1'b0;
            result     <= '0;
            calc_start <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            operand1   <= op1_nxt;
            operand2   <= op2_nxt;
            operator   <= opr_nxt;
            pending_op <= pend_nxt;
            chain      <= chain_nxt;
            result     <= res_nxt;
            calc_start <= start_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

    // While waiting on the calculate unit the last entered operand stays on screen.
    always_comb begin
        fnd_serial = '0;
        case (state)
            ST_OP1, ST_OP2: fnd_serial = acc_value;
            ST_OPR:         fnd_serial = operand1;
            ST_EXEC:        fnd_serial = operand2;
            ST_RES:         fnd_serial = result;
            default:        fnd_serial = '0;
        endcase
    end

    assign disp_err = (state == ST_ERR);
    assign busy     = (state == ST_EXEC);

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed calculator scenarios plus random key/result
// traffic, all checked against a behavioural calculator model.
module tb_calc_sequencer;

    localparam int MAX_DIGITS = 8;
    localparam int TIMEOUT    = 64;

    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12, K_DIV = 4'd13;
    localparam logic [3:0] K_EQ  = 4'd14, K_SIGN = 4'd15;

    localparam int PH_ENTER1 = 0, PH_CHOSEN = 1, PH_ENTER2 = 2;
    localparam int PH_WAIT   = 3, PH_SHOW   = 4, PH_ERROR  = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               key_valid = 1'b0;
    logic [3:0]         eBCD = 4'd0;
    logic               calc_done = 1'b0;
    logic               calc_err = 1'b0;
    logic signed [31:0] calc_result = '0;
    logic signed [31:0] operand1, operand2, fnd_serial;
    logic [2:0]         operator;
    logic               calc_start, disp_err, busy;

    int total = 0;
    int bad   = 0;

    calc_sequencer #(.MAX_DIGITS(MAX_DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .sw_clk      (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .eBCD        (eBCD),
        .calc_done   (calc_done),
        .calc_err    (calc_err),
        .calc_result (calc_result),
        .operand1    (operand1),
        .operand2    (operand2),
        .operator    (operator),
        .calc_start  (calc_start),
        .fnd_serial  (fnd_serial),
        .disp_err    (disp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural calculator model ----------------
    int     m_phase = PH_ENTER1;
    longint m_mag = 0;
    bit     m_neg = 0;
    int     m_ndig = 0;
    int     m_op1 = 0, m_op2 = 0, m_opr = 0, m_pend = 0, m_res = 0;
    bit     m_chain = 0, m_start = 0;
    int     cyc = 0, start_cyc = 0;

    function automatic int buf_val();
        return m_neg ? int'(-m_mag) : int'(m_mag);
    endfunction

    task automatic buf_clear();
        m_mag = 0; m_neg = 0; m_ndig = 0;
    endtask

    task automatic buf_edit(input bit dig, input bit sgn, input int k);
        if (dig && m_ndig < MAX_DIGITS) begin
            m_mag = m_mag * 10 + k;
            m_ndig++;
        end
        if (sgn) m_neg = !m_neg;
    endtask

    task automatic clear_all();
        m_op1 = 0; m_op2 = 0; m_opr = 0; m_pend = 0; m_res = 0; m_chain = 0;
        buf_clear();
    endtask

    function automatic int shown();
        case (m_phase)
            PH_ENTER1, PH_ENTER2: return buf_val();
            PH_CHOSEN:            return m_op1;
            PH_SHOW:              return m_res;
            default:              return 0;
        endcase
    endfunction

    task automatic model_step();
        int k;
        bit dig, sgn, opk, eq;
        k   = int'(eBCD);
        dig = key_valid && k <= 9;
        sgn = key_valid && k == 15;
        eq  = key_valid && k == 14;
        opk = key_valid && k >= 10 && k <= 13;
        m_start = 0;
        if (!rst) begin
            clear_all();
            m_phase = PH_ENTER1;
        end else begin
            case (m_phase)
                PH_ENTER1: begin
                    buf_edit(dig, sgn, k);
                    if (opk) begin
                        m_op1 = buf_val(); m_opr = k - 10; buf_clear(); m_phase = PH_CHOSEN;
                    end
                end
                PH_CHOSEN: begin
                    if (dig || sgn) begin
                        buf_edit(dig, sgn, k); m_phase = PH_ENTER2;
                    end else if (opk) m_opr = k - 10;
                end
                PH_ENTER2: begin
                    buf_edit(dig, sgn, k);
                    if (eq || opk) begin
                        m_op2 = buf_val(); buf_clear(); m_start = 1;
                        start_cyc = cyc + 1; m_chain = opk;
                        if (opk) m_pend = k - 10;
                        m_phase = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (calc_done) begin
                        if (calc_err) m_phase = PH_ERROR;
                        else if (m_chain) begin
                            m_op1 = calc_result; m_opr = m_pend; m_chain = 0; m_phase = PH_CHOSEN;
                        end else begin
                            m_res = calc_result; m_phase = PH_SHOW;
                        end
                    end else if (cyc - start_cyc == TIMEOUT - 1) m_phase = PH_ERROR;
                end
                PH_SHOW: begin
                    if (opk) begin
                        m_op1 = m_res; m_opr = k - 10; m_phase = PH_CHOSEN;
                    end else if (dig || sgn) begin
                        clear_all(); buf_edit(dig, sgn, k); m_phase = PH_ENTER1;
                    end
                end
                default: begin
                    if (key_valid) begin
                        clear_all(); m_phase = PH_ENTER1;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: advance the model on each edge, then check outputs.
    always @(posedge clk) begin
        model_step();
        #1;
        check("operand1", operand1, m_op1);
        check("operand2", operand2, m_op2);
        check("operator", operator, m_opr);
        check("calc_start", calc_start, m_start);
        check("busy", busy, m_phase == PH_WAIT);
        check("disp_err", disp_err, m_phase == PH_ERROR);
        if (m_phase != PH_WAIT) check("fnd_serial", fnd_serial, shown());
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        eBCD      = k;
        @(negedge clk);
        key_valid = 1'b0;
        eBCD      = 4'($urandom);
    endtask

    task automatic respond(input int d, input bit err, input int res);
        repeat (d) @(negedge clk);
        calc_done   = 1'b1;
        calc_err    = err;
        calc_result = res;
        @(negedge clk);
        calc_done   = 1'b0;
        calc_err    = 1'($urandom);
        calc_result = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic void calc_ref(input int a, input int b, input int op,
                                     output int r, output bit e);
        longint x;
        e = 0;
        case (op)
            0: x = longint'(a) + longint'(b);
            1: x = longint'(a) - longint'(b);
            2: x = longint'(a) * longint'(b);
            default: begin
                if (b == 0) begin e = 1; x = 0; end
                else x = longint'(a) / longint'(b);
            end
        endcase
        if (x > 64'sd2147483647 || x < -64'sd2147483648) e = 1;
        r = int'(x);
    endfunction

    function automatic logic [3:0] pick_key();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 5) return 4'($urandom_range(0, 9));
        if (sel <= 7) return 4'($urandom_range(10, 13));
        if (sel == 8) return K_EQ;
        return K_SIGN;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        bit e;
        repeat (3) @(negedge clk);
        check("reset_operand1", operand1, 0);
        check("reset_fnd", fnd_serial, 0);
        check("reset_start", calc_start, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;

        // 12 + 3 = 15
        press(4'd1); press(4'd2); press(K_ADD); press(4'd3); press(K_EQ);
        check("t1_start", calc_start, 1);
        check("t1_operand1", operand1, 12);
        check("t1_operand2", operand2, 3);
        check("t1_operator", operator, 0);
        check("t1_model_op1", m_op1, 12);
        respond(2, 1'b0, 15);
        check("t1_fnd", fnd_serial, 15);

        // -5 * 4 = -20
        press(4'd5); press(K_SIGN); press(K_MUL); press(4'd4); press(K_EQ);
        check("t2_operand1", operand1, -5);
        check("t2_operator", operator, 2);
        respond(1, 1'b0, -20);
        check("t2_fnd", fnd_serial, -20);

        // digit limit
        for (int i = 0; i < 10; i++) press(4'd9);
        check("t3_fnd_limit", fnd_serial, 99999999);
        check("t3_model_limit", shown(), 99999999);

        // 8 / 0 -> error, then recovery
        do_reset();
        press(4'd8); press(K_DIV); press(4'd0); press(K_EQ);
        respond(1, 1'b1, 0);
        check("t4_disp_err", disp_err, 1);
        check("t4_fnd", fnd_serial, 0);
        press(4'd7);
        check("t4_after_key_fnd", fnd_serial, 0);
        check("t4_after_key_err", disp_err, 0);
        press(4'd3);
        check("t4_digit_fnd", fnd_serial, 3);

        // chained operation 2 + 3 - 1 = 4
        do_reset();
        press(4'd2); press(K_ADD); press(4'd3); press(K_SUB);
        respond(1, 1'b0, 5);
        check("t5_chain_op1", operand1, 5);
        check("t5_chain_opr", operator, 1);
        check("t5_chain_fnd", fnd_serial, 5);
        press(4'd1); press(K_EQ);
        check("t5_start", calc_start, 1);
        check("t5_operand1", operand1, 5);
        check("t5_operand2", operand2, 1);
        check("t5_operator", operator, 1);
        respond(0, 1'b0, 4);
        check("t5_fnd", fnd_serial, 4);

        // timeout and key ignored during EXEC
        do_reset();
        press(4'd1); press(K_ADD); press(4'd1); press(K_EQ);
        press(4'd7);
        n = 1;
        check("t6_op1_hold", operand1, 1);
        check("t6_op2_hold", operand2, 1);
        while (!disp_err && n < TIMEOUT + 4) begin
            @(negedge clk);
            n++;
        end
        check("t6_timeout_cycles", n, TIMEOUT);
        check("t6_fnd_err", fnd_serial, 0);

        // reset mid-EXEC
        press(4'd0);
        press(4'd4); press(K_ADD); press(4'd5); press(K_EQ);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t7_busy", busy, 0);
        check("t7_operand1", operand1, 0);
        check("t7_operand2", operand2, 0);
        check("t7_operator", operator, 0);
        check("t7_fnd", fnd_serial, 0);
        @(negedge clk);
        rst = 1'b1;

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rst         = ($urandom_range(0, 399) != 0);
            key_valid   = ($urandom_range(0, 2) == 0);
            eBCD        = pick_key();
            calc_done   = 1'b0;
            calc_err    = 1'($urandom);
            calc_result = $urandom;
            if (m_phase == PH_WAIT && $urandom_range(0, 3) == 0) begin
                calc_ref(m_op1, m_op2, m_opr, r, e);
                calc_done   = 1'b1;
                calc_err    = e || ($urandom_range(0, 15) == 0);
                calc_result = r;
            end else if ($urandom_range(0, 19) == 0) begin
                calc_done = 1'b1;
            end
            @(negedge clk);
        end
        rst = 1'b1;
        key_valid = 1'b0;
        calc_done = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
